// File: rtl/thread_issue_ctrl_pkg.sv
// Shared definitions for the per-thread issue controller: thread-state
// encoding, thread-ID width, PC step and default reset PCs.
package thread_pkg;

  localparam int TID_W = 1;
  typedef logic [TID_W-1:0] tid_t;

  typedef enum logic [1:0] {
    TS_RUN     = 2'd0,
    TS_WAIT_MD = 2'd1,
    TS_HALT    = 2'd2
  } tstate_t;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] DEF_RESET_PC0 = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC1 = 32'h0000_1000;

endpackage

// File: rtl/thread_issue_ctrl_if.sv
// Selector/writeback-facing bundle of the issue controller. The master side
// drives selector tags, writeback events and halts; the slave side is the
// controller returning ready flags, the issued PC and the error flag.
interface thread_issue_ctrl_if;
  import thread_pkg::*;

  logic        en;
  tid_t        dt;
  logic        st0;
  logic        st1;
  tid_t        wt;
  logic        wb_valid;
  logic        wb_redirect;
  logic [31:0] wb_target;
  logic        wb_md_start;
  logic        md_done;
  tid_t        md_thread;
  logic        halt_req;
  tid_t        halt_thread;
  logic        fasmds0;
  logic        fasmds1;
  logic [31:0] pc_out;
  tid_t        pc_thread;
  logic        pc_valid;
  logic        sel_err;

  modport master (
    output en, dt, st0, st1, wt, wb_valid, wb_redirect, wb_target,
           wb_md_start, md_done, md_thread, halt_req, halt_thread,
    input  fasmds0, fasmds1, pc_out, pc_thread, pc_valid, sel_err
  );

  modport slave (
    input  en, dt, st0, st1, wt, wb_valid, wb_redirect, wb_target,
           wb_md_start, md_done, md_thread, halt_req, halt_thread,
    output fasmds0, fasmds1, pc_out, pc_thread, pc_valid, sel_err
  );

endinterface

// File: rtl/thread_issue_ctrl_ctx.sv
// One thread's context: its PC register and its RUN/WAIT_MD/HALT state
// machine. The ready flag is a register so the selector sees no
// combinational path back from its own decisions.
module thread_ctx
  import thread_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        issue,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        md_start,
  input  logic        md_done,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        ready,
  output logic        err
);

  tstate_t state;

  // Halt dominates; a start in the same cycle as a done leaves the thread waiting.
  function automatic tstate_t next_state(input tstate_t cur, input logic h,
                                         input logic ms, input logic md);
    tstate_t nxt;
    nxt = cur;
    if (h) begin
      nxt = TS_HALT;
    end else begin
      case (cur)
        TS_RUN:     if (ms) nxt = TS_WAIT_MD;
        TS_WAIT_MD: if (md && !ms) nxt = TS_RUN;
        default:    nxt = TS_HALT;
      endcase
    end
    return nxt;
  endfunction

  // State, ready flag and PC; redirect overrides the post-issue increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TS_RUN;
      ready <= 1'b1;
      pc    <= RESET_PC;
    end else if (en) begin
      state <= next_state(state, halt, md_start, md_done);
      ready <= (next_state(state, halt, md_start, md_done) == TS_RUN);
      if (redirect) begin
        pc <= target;
      end else if (issue) begin
        pc <= pc + PC_INC;
      end
    end
  end

  // A completion for a thread that is not waiting is a protocol error.
  assign err = md_done && (state != TS_WAIT_MD);

endmodule

// File: rtl/thread_issue_ctrl.sv
// Per-thread issue controller for the two-thread interleaved core. Decodes
// the selector/writeback thread tags onto two thread contexts, registers the
// issued PC and accumulates a sticky protocol-error flag.
module thread_issue_ctrl
  import thread_pkg::*;
#(
  parameter logic [31:0] RESET_PC0 = DEF_RESET_PC0,
  parameter logic [31:0] RESET_PC1 = DEF_RESET_PC1
) (
  input  logic               clk,
  input  logic               rst_n,
  thread_issue_ctrl_if.slave bus
);

  logic [31:0] pc0, pc1;
  logic        rdy0, rdy1;
  logic        err0, err1;
  logic        issue, sel0, sel1, redir;
  logic        proto_err;

  assign issue = bus.en && (rdy0 || rdy1);
  assign sel0  = (bus.dt == 1'b0);
  assign sel1  = (bus.dt == 1'b1);
  assign redir = bus.wb_valid && bus.wb_redirect;

  assign proto_err = (bus.st0 && !rdy0) || (bus.st1 && !rdy1) ||
                     (bus.st0 && bus.st1) ||
                     (issue && (sel0 ? !rdy0 : !rdy1)) ||
                     err0 || err1;

  thread_ctx #(.RESET_PC(RESET_PC0)) u_ctx0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .issue    (issue && sel0 && !bus.st0),
    .redirect (redir && (bus.wt == 1'b0)),
    .target   (bus.wb_target),
    .md_start (bus.wb_valid && bus.wb_md_start && (bus.wt == 1'b0)),
    .md_done  (bus.md_done && (bus.md_thread == 1'b0)),
    .halt     (bus.halt_req && (bus.halt_thread == 1'b0)),
    .pc       (pc0),
    .ready    (rdy0),
    .err      (err0)
  );

  thread_ctx #(.RESET_PC(RESET_PC1)) u_ctx1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .issue    (issue && sel1 && !bus.st1),
    .redirect (redir && (bus.wt == 1'b1)),
    .target   (bus.wb_target),
    .md_start (bus.wb_valid && bus.wb_md_start && (bus.wt == 1'b1)),
    .md_done  (bus.md_done && (bus.md_thread == 1'b1)),
    .halt     (bus.halt_req && (bus.halt_thread == 1'b1)),
    .pc       (pc1),
    .ready    (rdy1),
    .err      (err1)
  );

  // Issue stage to fetch-PC output; pc_out shows the pre-redirect PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pc_out    <= 32'h0;
      bus.pc_thread <= 1'b0;
      bus.pc_valid  <= 1'b0;
      bus.sel_err   <= 1'b0;
    end else if (bus.en) begin
      if (issue) begin
        bus.pc_out    <= sel0 ? pc0 : pc1;
        bus.pc_thread <= bus.dt;
        bus.pc_valid  <= 1'b1;
      end else begin
        bus.pc_valid  <= 1'b0;
      end
      if (proto_err) begin
        bus.sel_err <= 1'b1;
      end
    end
  end

  assign bus.fasmds0 = rdy0;
  assign bus.fasmds1 = rdy1;

endmodule

// File: tb/tb_thread_issue_ctrl.sv
// Bench for thread_issue_ctrl: a vector table for alternation, enable freeze,
// redirects and PC wrap, then hand-written multi-cycle, halt and reset
// sequences. Issued PCs go through an expected-value queue.
module tb_thread_issue_ctrl;
  import thread_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  thread_issue_ctrl_if bus();

  thread_issue_ctrl #(.RESET_PC0(32'h0000_0000), .RESET_PC1(32'h0000_1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        th;
  } sb_t;

  typedef struct {
    bit          en;
    bit          dt;
    bit          st0;
    bit          st1;
    bit          rd;
    bit          wt;
    logic [31:0] tgt;
    bit          iss;
    logic [31:0] epc;
  } vec_t;

  sb_t         sbq[$];
  vec_t        tbl[18];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_pc = 32'h0;
  bit          last_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.en = 1'b1;  bus.dt = 1'b0;  bus.st0 = 1'b0;  bus.st1 = 1'b0;
    bus.wt = 1'b0;  bus.wb_valid = 1'b0;  bus.wb_redirect = 1'b0;
    bus.wb_target = 32'h0;  bus.wb_md_start = 1'b0;  bus.md_done = 1'b0;
    bus.md_thread = 1'b0;  bus.halt_req = 1'b0;  bus.halt_thread = 1'b0;
  endtask

  // One clock: queue the expected issue, then check the registered output.
  task automatic tick(input bit iss, input logic [31:0] epc);
    bit  en_s;
    sb_t e;
    en_s = bus.en;
    if (en_s && iss) sbq.push_back('{epc, bus.dt});
    @(posedge clk);
    #1;
    if (en_s) begin
      chk("pc_valid", {31'h0, bus.pc_valid}, {31'h0, iss});
      if (bus.pc_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_extra: got pc %h expected no output", bus.pc_out);
        end else begin
          e = sbq.pop_front();
          chk("pc_out", bus.pc_out, e.pc);
          chk("pc_thread", {31'h0, bus.pc_thread}, {31'h0, e.th});
          last_pc = e.pc;
        end
      end else if (iss && sbq.size() != 0) begin
        e = sbq.pop_front();
      end
      last_valid = iss;
    end else begin
      chk("frz_pc_out", bus.pc_out, last_pc);
      chk("frz_pc_valid", {31'h0, bus.pc_valid}, {31'h0, last_valid});
    end
  endtask

  task automatic chk_ready(input string nm, input bit f0, input bit f1);
    chk({nm, "_f0"}, {31'h0, bus.fasmds0}, {31'h0, f0});
    chk({nm, "_f1"}, {31'h0, bus.fasmds1}, {31'h0, f1});
  endtask

  initial begin
    //          en dt st0 st1 rd wt tgt            iss epc
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 32'h0,          1, 32'h0000_0000};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 32'h0,          1, 32'h0000_1000};
    tbl[2]  = '{1, 0, 0, 1, 0, 0, 32'h0,          1, 32'h0000_0004};
    tbl[3]  = '{1, 1, 1, 0, 0, 0, 32'h0,          1, 32'h0000_1004};
    tbl[4]  = '{0, 0, 0, 1, 1, 0, 32'h000D_EAD0,  0, 32'h0};
    tbl[5]  = '{0, 0, 0, 1, 1, 0, 32'h000D_EAD0,  0, 32'h0};
    tbl[6]  = '{0, 0, 0, 1, 1, 0, 32'h000D_EAD0,  0, 32'h0};
    tbl[7]  = '{1, 0, 0, 1, 0, 0, 32'h0,          1, 32'h0000_0008};
    tbl[8]  = '{1, 1, 1, 0, 1, 1, 32'h0000_2000,  1, 32'h0000_1008};
    tbl[9]  = '{1, 0, 0, 1, 0, 0, 32'h0,          1, 32'h0000_000C};
    tbl[10] = '{1, 1, 1, 0, 0, 0, 32'h0,          1, 32'h0000_2000};
    tbl[11] = '{1, 0, 0, 1, 1, 0, 32'hFFFF_FFFC,  1, 32'h0000_0010};
    tbl[12] = '{1, 1, 1, 0, 0, 0, 32'h0,          1, 32'h0000_2004};
    tbl[13] = '{1, 0, 0, 1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC};
    tbl[14] = '{1, 1, 1, 0, 0, 0, 32'h0,          1, 32'h0000_2008};
    tbl[15] = '{1, 0, 0, 1, 0, 0, 32'h0,          1, 32'h0000_0000};
    tbl[16] = '{1, 0, 0, 1, 1, 1, 32'h0000_3000,  1, 32'h0000_0004};
    tbl[17] = '{1, 1, 1, 0, 0, 0, 32'h0,          1, 32'h0000_3000};

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_pc_out", bus.pc_out, 32'h0);
    chk("rst_pc_thread", {31'h0, bus.pc_thread}, 32'h0);
    chk("rst_pc_valid", {31'h0, bus.pc_valid}, 32'h0);
    chk("rst_sel_err", {31'h0, bus.sel_err}, 32'h0);
    chk_ready("rst", 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      idle();
      bus.en = tbl[i].en;  bus.dt = tbl[i].dt;
      bus.st0 = tbl[i].st0;  bus.st1 = tbl[i].st1;
      bus.wb_valid = tbl[i].rd;  bus.wb_redirect = tbl[i].rd;
      bus.wt = tbl[i].wt;  bus.wb_target = tbl[i].tgt;
      tick(tbl[i].iss, tbl[i].epc);
      chk_ready($sformatf("row%0d", i), 1'b1, 1'b1);
      chk($sformatf("row%0d_sel_err", i), {31'h0, bus.sel_err}, 32'h0);
    end

    // Multi-cycle op on thread 0 while thread 1 keeps issuing.
    idle(); bus.dt = 1; bus.st0 = 1; bus.wb_valid = 1; bus.wb_md_start = 1; bus.wt = 0;
    tick(1, 32'h0000_3004); chk_ready("md_start", 1'b0, 1'b1);
    idle(); bus.dt = 1;
    tick(1, 32'h0000_3008); chk_ready("md_wait", 1'b0, 1'b1);
    idle(); bus.dt = 1; bus.md_done = 1; bus.md_thread = 0;
    tick(1, 32'h0000_300C); chk_ready("md_done", 1'b1, 1'b1);
    idle(); bus.dt = 0; bus.st1 = 1;
    tick(1, 32'h0000_0008);
    chk("md_sel_err", {31'h0, bus.sel_err}, 32'h0);

    // Done and a new start for the same thread in one cycle: stays waiting.
    idle(); bus.dt = 1; bus.st0 = 1; bus.wb_valid = 1; bus.wb_md_start = 1; bus.wt = 0;
    tick(1, 32'h0000_3010); chk_ready("mc_start", 1'b0, 1'b1);
    idle(); bus.dt = 1; bus.wb_valid = 1; bus.wb_md_start = 1; bus.wt = 0;
    bus.md_done = 1; bus.md_thread = 0;
    tick(1, 32'h0000_3014); chk_ready("mc_both", 1'b0, 1'b1);
    idle(); bus.dt = 1; bus.md_done = 1; bus.md_thread = 0;
    tick(1, 32'h0000_3018); chk_ready("mc_done", 1'b1, 1'b1);
    idle(); bus.dt = 0; bus.st1 = 1;
    tick(1, 32'h0000_000C);
    chk("mc_sel_err", {31'h0, bus.sel_err}, 32'h0);

    // Halt both threads; nothing issues, then a stray done flags an error.
    idle(); bus.dt = 1; bus.st0 = 1; bus.halt_req = 1; bus.halt_thread = 0;
    tick(1, 32'h0000_301C); chk_ready("halt0", 1'b0, 1'b1);
    idle(); bus.dt = 1; bus.halt_req = 1; bus.halt_thread = 1;
    tick(1, 32'h0000_3020); chk_ready("halt1", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      tick(0, 32'h0);
      chk_ready("halted", 1'b0, 1'b0);
      chk("halted_sel_err", {31'h0, bus.sel_err}, 32'h0);
    end
    idle(); bus.md_done = 1; bus.md_thread = 0;
    tick(0, 32'h0);
    chk("stray_done_err", {31'h0, bus.sel_err}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      idle();
      tick(0, 32'h0);
      chk("sticky_err", {31'h0, bus.sel_err}, 32'h1);
    end

    // Reset during WAIT_MD returns the thread to RUN; a late done is an error.
    rst_n = 1'b0;
    #1;
    chk_ready("rst2", 1'b1, 1'b1);
    chk("rst2_pc_valid", {31'h0, bus.pc_valid}, 32'h0);
    chk("rst2_sel_err", {31'h0, bus.sel_err}, 32'h0);
    sbq.delete(); last_pc = 32'h0; last_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(); bus.dt = 1; bus.st0 = 1; bus.wb_valid = 1; bus.wb_md_start = 1; bus.wt = 0;
    tick(1, 32'h0000_1000); chk_ready("rst_md", 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_ready("rst3", 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); bus.dt = 0; bus.st1 = 1; bus.md_done = 1; bus.md_thread = 0;
    tick(1, 32'h0000_0000);
    chk("late_done_err", {31'h0, bus.sel_err}, 32'h1);

    chk("sb_empty", sbq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
